raster_sweep: RTL and testbench

- Parametrised rectangular raster scanner for the VGA adapter pixel port.
- Given an origin, width, height and colour, it steps x/y across the rectangle row by row, presenting one pixel per enabled cycle with a plot strobe.
- Adds a start/busy/done handshake, a downstream stall, abort, fill/clear mode, loop mode and screen clipping.
- Sits between message/sprite control FSMs and the VGA adapter's x, y, colour and plot inputs.

---
 rtl/raster_sweep.sv | 164 ++++++++++++++++
 tb/tb_raster_sweep.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_sweep.sv
// raster_sweep: rectangular raster scanner feeding the VGA adapter pixel port.
// It steps (x, y) across a rectangle row by row and emits one pixel for each
// cycle that enable is high. Each pixel comes with a plot strobe that is
// cleared for off-screen or overflowed coordinates.
//
// Ports:
//   clock, reset          rising-edge clock; synchronous active-high reset
//   start                 request a sweep (sampled only when idle)
//   abort                 cancel the active sweep, return to idle
//   enable                downstream ready; 0 stalls the sweep
//   loop                  restart at the end of the rectangle instead of stopping
//   mode                  0 = fill with colour_in, 1 = clear (colour 0)
//   x0, y0                rectangle origin (latched at start)
//   width, height         rectangle size (latched at start)
//   colour_in             fill colour (latched at start)
//   x, y, colour, plot    registered pixel presented to the adapter
//   busy                  high while a sweep (or its done cycle) is active
//   done                  one-cycle end-of-rectangle pulse
module raster_sweep #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           abort,
  input  logic           enable,
  input  logic           loop,
  input  logic           mode,
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W-1:0] width,
  input  logic [Y_W-1:0] height,
  input  logic [C_W-1:0] colour_in,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [C_W-1:0] colour,
  output logic           plot,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  // Screen limits at the width of the full (carry-included) coordinate sums.
  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  state_t state, state_nxt;

  logic [X_W-1:0] x0_q, width_q, cx, cx_nxt, x_nxt;
  logic [Y_W-1:0] y0_q, height_q, cy, cy_nxt, y_nxt;
  logic           plot_nxt, done_nxt, latch_en;

  // Sums carry one extra bit so a wrapped coordinate is seen as off-screen
  // rather than aliasing back onto the left/top edge.
  logic [X_W:0] x_sum;
  logic [Y_W:0] y_sum;
  logic         on_screen, last_col, last_row;

  assign x_sum     = {1'b0, x0_q} + {1'b0, cx};
  assign y_sum     = {1'b0, y0_q} + {1'b0, cy};
  assign on_screen = (x_sum < SCR_W) && (y_sum < SCR_H);
  assign last_col  = (cx == width_q - X_W'(1));
  assign last_row  = (cy == height_q - Y_W'(1));

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cx_nxt    = cx;
    cy_nxt    = cy;
    x_nxt     = x;
    y_nxt     = y;
    plot_nxt  = 1'b0;
    done_nxt  = 1'b0;
    latch_en  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          latch_en = 1'b1;
          cx_nxt   = '0;
          cy_nxt   = '0;
          // An empty rectangle still completes the handshake with a done pulse.
          if (width == '0 || height == '0) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = SWEEP;
          end
        end
      end
      SWEEP: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (enable) begin
          x_nxt    = x_sum[X_W-1:0];
          y_nxt    = y_sum[Y_W-1:0];
          plot_nxt = on_screen;
          if (last_col) begin
            cx_nxt = '0;
            if (last_row) begin
              // done is registered alongside the last pixel so both are
              // presented in the same cycle, in loop mode as well.
              cy_nxt    = '0;
              done_nxt  = 1'b1;
              state_nxt = loop ? SWEEP : DONE;
            end else begin
              cy_nxt = cy + Y_W'(1);
            end
          end else begin
            cx_nxt = cx + X_W'(1);
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (reset) begin
      x0_q     <= '0;
      y0_q     <= '0;
      width_q  <= '0;
      height_q <= '0;
      cx       <= '0;
      cy       <= '0;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
      plot     <= 1'b0;
      done     <= 1'b0;
    end else begin
      cx   <= cx_nxt;
      cy   <= cy_nxt;
      x    <= x_nxt;
      y    <= y_nxt;
      plot <= plot_nxt;
      done <= done_nxt;
      if (latch_en) begin
        x0_q     <= x0;
        y0_q     <= y0;
        width_q  <= width;
        height_q <= height;
        colour   <= mode ? '0 : colour_in;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_raster_sweep.sv
// Directed testbench for raster_sweep. Inputs change 1 time unit after the
// rising edge, and outputs are sampled at that same point, so every check
// sees the result of the edge just taken.
module tb_raster_sweep;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, abort = 1'b0, enable = 1'b1, loop = 1'b0, mode = 1'b0;
  logic [7:0] x0 = '0, width = '0;
  logic [6:0] y0 = '0, height = '0;
  logic [2:0] colour_in = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  int n_vec = 0;
  int n_err = 0;

  // {plot, done, busy, x, y, colour}
  logic [20:0] obs, exp_v;

  raster_sweep dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .enable(enable), .loop(loop), .mode(mode), .x0(x0), .y0(y0),
    .width(width), .height(height), .colour_in(colour_in),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
    obs = {plot, done, busy, x, y, colour};
  endtask

  // Load operands and pulse start for one edge; the DUT leaves IDLE there.
  task automatic kick(input logic [7:0] ax, input logic [6:0] ay,
                      input logic [7:0] aw, input logic [6:0] ah,
                      input logic [2:0] ac, input logic am, input logic al);
    x0 = ax; y0 = ay; width = aw; height = ah; colour_in = ac;
    mode = am; loop = al; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_vec++;
    if (obs !== 21'd0) begin
      n_err++; $display("FAIL reset got %h want %h", obs, 21'd0);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    enable = 1'b1;
    kick(8'd10, 7'd20, 8'd4, 7'd2, 3'd5, 1'b0, 1'b0);
    n_vec++;
    if ({plot, done, busy} !== 3'b001) begin
      n_err++; $display("FAIL basic_start got %b want 001", {plot, done, busy});
    end
    for (int i = 0; i < 8; i++) begin
      step();
      exp_v = {1'b1, (i == 7), 1'b1, 8'(10 + i % 4), 7'(20 + i / 4), 3'd5};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL basic[%0d] got %h want %h", i, obs, exp_v);
      end
    end
    step();
    n_vec++;
    if ({plot, done, busy} !== 3'b000) begin
      n_err++; $display("FAIL basic_end got %b want 000", {plot, done, busy});
    end
  endtask

  task automatic test_stall();
    int p;
    kick(8'd10, 7'd20, 8'd4, 7'd2, 3'd5, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) begin
      enable = (k % 2 == 0);
      step();
      p = k / 2;
      exp_v = {(k % 2 == 0), (k == 14), 1'b1, 8'(10 + p % 4), 7'(20 + p / 4), 3'd5};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL stall[%0d] got %h want %h", k, obs, exp_v);
      end
    end
    enable = 1'b1;
    step();
    n_vec++;
    if ({plot, done, busy} !== 3'b000) begin
      n_err++; $display("FAIL stall_end got %b want 000", {plot, done, busy});
    end
  endtask

  task automatic test_clip();
    logic [7:0] ex;
    kick(8'd158, 7'd5, 8'd4, 7'd1, 3'd3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      ex = 8'(158 + i);
      exp_v = {(i < 2), (i == 3), 1'b1, ex, 7'd5, 3'd3};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL clip[%0d] got %h want %h", i, obs, exp_v);
      end
    end
    step();
    // x0=255: 255 is off-screen, 256 overflows to 0 and must not plot.
    kick(8'd255, 7'd5, 8'd2, 7'd1, 3'd3, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      ex = (i == 0) ? 8'd255 : 8'd0;
      exp_v = {1'b0, (i == 1), 1'b1, ex, 7'd5, 3'd3};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL wrap[%0d] got %h want %h", i, obs, exp_v);
      end
    end
    step();
  endtask

  task automatic test_degenerate();
    for (int t = 0; t < 2; t++) begin
      if (t == 0) kick(8'd3, 7'd3, 8'd0, 7'd3, 3'd1, 1'b0, 1'b0);
      else        kick(8'd3, 7'd3, 8'd5, 7'd0, 3'd1, 1'b0, 1'b0);
      n_vec++;
      if ({plot, done, busy} !== 3'b011) begin
        n_err++; $display("FAIL degen[%0d] got %b want 011", t, {plot, done, busy});
      end
      step();
      n_vec++;
      if ({plot, done, busy} !== 3'b000) begin
        n_err++; $display("FAIL degen_end[%0d] got %b want 000", t, {plot, done, busy});
      end
    end
  endtask

  task automatic test_loop();
    kick(8'd1, 7'd2, 8'd2, 7'd2, 3'd6, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step();
      exp_v = {1'b1, (i % 4 == 3), 1'b1, 8'(1 + i % 2), 7'(2 + (i / 2) % 2), 3'd6};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL loop[%0d] got %h want %h", i, obs, exp_v);
      end
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    loop  = 1'b0;
    n_vec++;
    if ({plot, done, busy} !== 3'b000) begin
      n_err++; $display("FAIL loop_abort got %b want 000", {plot, done, busy});
    end
  endtask

  task automatic test_abort();
    kick(8'd10, 7'd20, 8'd4, 7'd2, 3'd5, 1'b0, 1'b0);
    step(); step(); step();   // third pixel now presented
    n_vec++;
    if ({plot, x} !== {1'b1, 8'd12}) begin
      n_err++; $display("FAIL abort_pre got %h want %h", {plot, x}, {1'b1, 8'd12});
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({plot, done, busy} !== 3'b000) begin
        n_err++; $display("FAIL abort[%0d] got %b want 000", i, {plot, done, busy});
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    kick(8'd10, 7'd20, 8'd4, 7'd2, 3'd5, 1'b0, 1'b0);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_vec++;
    if (obs !== 21'd0) begin
      n_err++; $display("FAIL reset_mid got %h want %h", obs, 21'd0);
    end
  endtask

  task automatic test_start_ignored();
    kick(8'd10, 7'd20, 8'd4, 7'd2, 3'd5, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      // Disturb every operand and re-request a sweep mid-flight.
      start = (i >= 1 && i <= 5);
      x0 = 8'd50; y0 = 7'd60; width = 8'd9; height = 7'd9; colour_in = 3'd2; mode = 1'b1;
      step();
      exp_v = {1'b1, (i == 7), 1'b1, 8'(10 + i % 4), 7'(20 + i / 4), 3'd5};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL ignore[%0d] got %h want %h", i, obs, exp_v);
      end
    end
    start = 1'b0;
    step();
    mode = 1'b0;
  endtask

  task automatic test_clear_mode();
    kick(8'd40, 7'd30, 8'd3, 7'd1, 3'd7, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      exp_v = {1'b1, (i == 2), 1'b1, 8'(40 + i), 7'd30, 3'd0};
      n_vec++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL clear[%0d] got %h want %h", i, obs, exp_v);
      end
    end
    step();
    mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_clip();
    test_degenerate();
    test_loop();
    test_abort();
    test_reset_mid();
    test_start_ignored();
    test_clear_mode();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
